alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 cmd_valid  input  1  command offered.
REQ-004 cmd_ready  output  1  block can accept a command.
REQ-005 cmd_op  input  3  0 ADD, 1 NAND, 2 NOT(a), 3 ZERO, 4 AND, 5 OR, 6 SUB(a-b), 7 XOR.
REQ-006 cmd_a, cmd_b  input  8 each  operands.
REQ-007 res_valid  output  1  result held.
REQ-008 res_ready  input  1  consumer takes result.
REQ-009 res_data  output  8  result; res_err  output  1  unsupported command.
REQ-010 alu_x, alu_y  output  8 each; alu_op  output  2 (00 add, 01 nand, 10 not-x, 11 zero): drive the registered ALU.
REQ-011 alu_z  input  8  ALU result, valid one cycle after its inputs were driven.

Function
REQ-012 States IDLE, STEP, CAPTURE, DONE; handshake cycles are transfers when valid and ready are both high.
REQ-013 cmd_ready SHALL be 1 only in IDLE; on transfer latch cmd_op/a/b, step=0, go STEP.
REQ-014 STEP: drive one micro-op per cycle from ROM(cmd_op, step); on last step go CAPTURE, else step+1.
REQ-015 Micro-op operand sources: A, B, Z (current alu_z), T0, T1, ONE (8'h01); save bits load alu_z into T0/T1 in that cycle.
REQ-016 Sequences: ADD/NAND/NOT/ZERO one step; AND: NAND A,B; NOT Z. OR: NOT A; NOT B save T0; NAND T0,Z. SUB: NOT B; ADD A,Z; ADD Z,ONE. XOR: NAND A,B; NAND A,Z save T0; NAND B,T0 save T1; NAND T1,Z.
REQ-017 CAPTURE: res_data <= alu_z, res_err <= 0, go DONE.
REQ-018 DONE: res_valid=1, res_data/res_err stable until transfer, then IDLE; no command accepted in DONE.
REQ-019 Latency: handshake in cycle 0 -> res_valid first high in cycle N+2, N = step count.
REQ-020 Arithmetic is modulo 256; no carry/borrow output.
REQ-021 Outside STEP: alu_op=11, alu_x=alu_y=0.
REQ-022 cmd_valid while not in IDLE SHALL be ignored (not lost state, not accepted).

Reset
REQ-023 rst high: state IDLE, res_valid=0, res_data=0, res_err=0, T0=T1=0, step=0, alu_* outputs idle values, immediately and at any point mid-sequence.
REQ-024 First accept possible in the first clock edge after rst falls.

Configuration
REQ-025 Macro ALU_SEQUENCER_XOR_EN defined: cmd_op 7 runs the XOR sequence (REQ-016).
REQ-026 Undefined: cmd_op 7 goes IDLE->DONE directly, res_data=0, res_err=1, res_valid in cycle 1; no ALU micro-ops issued.

Structure
REQ-027 Package alu_sequencer_pkg: ALU opcode constants, command codes, operand-source encoding, state encoding, per-command step counts.
REQ-028 Sub-module alu_sequencer_rom: combinational (cmd_op, step) -> alu_op, x_src, y_src, save_t0, save_t1, last.

Verification
REQ-029 ADD a=F0 b=20 -> res_data 10, res_err 0, res_valid cycle 3.
REQ-030 SUB a=05 b=07 -> FE at cycle 5; AND F0,3C -> 30 at cycle 4; OR A0,0C -> AC at cycle 5.
REQ-031 XOR 5A,FF with macro -> A5 at cycle 6; without macro -> 00, res_err 1, cycle 1.
REQ-032 res_ready low 3 cycles after ADD 01,01 -> res_data 02 stable, cmd_ready 0, concurrent cmd_valid ignored; release -> IDLE next cycle.
REQ-033 rst pulsed during SUB step 1 -> all outputs reset values at once, alu_op 11; next ADD 03,04 after release -> 07 at cycle 3.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_pkg
// Brief    : Shared constants for the ALU micro-sequencer: ALU opcodes,
//            command codes, operand-source encoding, FSM state encoding and
//            per-command micro-step counts.
//            Optional feature macro: ALU_SEQUENCER_XOR_EN (XOR sequence).
// Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  // Operations of the external registered ALU
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_NAND = 2'b01;
  localparam logic [1:0] ALU_NOTX = 2'b10;
  localparam logic [1:0] ALU_ZERO = 2'b11;

  // Command codes presented on cmd_op
  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_NAND = 3'd1;
  localparam logic [2:0] CMD_NOT  = 3'd2;
  localparam logic [2:0] CMD_ZERO = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_OR   = 3'd5;
  localparam logic [2:0] CMD_SUB  = 3'd6;
  localparam logic [2:0] CMD_XOR  = 3'd7;

  // Operand sources for the ALU x/y inputs; SRC_NONE drives zero on
  // operands the selected ALU operation ignores
  localparam logic [2:0] SRC_A    = 3'd0;
  localparam logic [2:0] SRC_B    = 3'd1;
  localparam logic [2:0] SRC_Z    = 3'd2;
  localparam logic [2:0] SRC_T0   = 3'd3;
  localparam logic [2:0] SRC_T1   = 3'd4;
  localparam logic [2:0] SRC_ONE  = 3'd5;
  localparam logic [2:0] SRC_NONE = 3'd6;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STEP    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // XOR is the only optional command; without it cmd_op 7 is rejected
`ifdef ALU_SEQUENCER_XOR_EN
  localparam logic XOR_EN = 1'b1;
`else
  localparam logic XOR_EN = 1'b0;
`endif

  // Number of micro-steps each command issues to the ALU
  function automatic logic [2:0] cmd_steps(input logic [2:0] op);
    case (op)
      CMD_AND: cmd_steps = 3'd2;
      CMD_OR:  cmd_steps = 3'd3;
      CMD_SUB: cmd_steps = 3'd3;
      CMD_XOR: cmd_steps = XOR_EN ? 3'd4 : 3'd1;
      default: cmd_steps = 3'd1;
    endcase
  endfunction

  // A command runs micro-ops unless it is a disabled optional command
  function automatic logic cmd_supported(input logic [2:0] op);
    cmd_supported = (op != CMD_XOR) || XOR_EN;
  endfunction

endpackage : alu_sequencer_pkg
`default_nettype wire

// File: rtl/alu_sequencer_rom.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_rom
// Brief    : Combinational micro-op ROM: (command, step) -> ALU operation,
//            operand sources, temp-register save strobes and last-step flag.
//            XOR entries exist only with ALU_SEQUENCER_XOR_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer_rom
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] op,
  input  logic [1:0] step,
  output logic [1:0] alu_op,
  output logic [2:0] x_src,
  output logic [2:0] y_src,
  output logic       save_t0,
  output logic       save_t1,
  output logic       last
);

  // Micro-op table lookup; unused (command, step) pairs decode to ZERO
  always_comb begin
    alu_op  = ALU_ZERO;
    x_src   = SRC_NONE;
    y_src   = SRC_NONE;
    save_t0 = 1'b0;
    save_t1 = 1'b0;
    case (op)
      CMD_ADD:  begin alu_op = ALU_ADD;  x_src = SRC_A; y_src = SRC_B; end
      CMD_NAND: begin alu_op = ALU_NAND; x_src = SRC_A; y_src = SRC_B; end
      CMD_NOT:  begin alu_op = ALU_NOTX; x_src = SRC_A; end
      CMD_ZERO: begin alu_op = ALU_ZERO; end
      CMD_AND: begin
        // AND = NOT(NAND(a,b))
        if (step == 2'd0) begin
          alu_op = ALU_NAND; x_src = SRC_A; y_src = SRC_B;
        end else begin
          alu_op = ALU_NOTX; x_src = SRC_Z;
        end
      end
      CMD_OR: begin
        // OR = NAND(~a, ~b); ~a is parked in T0 while ~b is computed
        case (step)
          2'd0:    begin alu_op = ALU_NOTX; x_src = SRC_A; end
          2'd1:    begin alu_op = ALU_NOTX; x_src = SRC_B; save_t0 = 1'b1; end
          default: begin alu_op = ALU_NAND; x_src = SRC_T0; y_src = SRC_Z; end
        endcase
      end
      CMD_SUB: begin
        // SUB = a + ~b + 1 (two's complement)
        case (step)
          2'd0:    begin alu_op = ALU_NOTX; x_src = SRC_B; end
          2'd1:    begin alu_op = ALU_ADD;  x_src = SRC_A; y_src = SRC_Z; end
          default: begin alu_op = ALU_ADD;  x_src = SRC_Z; y_src = SRC_ONE; end
        endcase
      end
      CMD_XOR: begin
        // Four-NAND XOR: n=NAND(a,b); XOR = NAND(NAND(a,n), NAND(b,n))
        if (XOR_EN) begin
          case (step)
            2'd0: begin alu_op = ALU_NAND; x_src = SRC_A; y_src = SRC_B; end
            2'd1: begin alu_op = ALU_NAND; x_src = SRC_A; y_src = SRC_Z; save_t0 = 1'b1; end
            2'd2: begin alu_op = ALU_NAND; x_src = SRC_B; y_src = SRC_T0; save_t1 = 1'b1; end
            default: begin alu_op = ALU_NAND; x_src = SRC_T1; y_src = SRC_Z; end
          endcase
        end
      end
      default: ;
    endcase
    last = ({1'b0, step} == (cmd_steps(op) - 3'd1));
  end

endmodule : alu_sequencer_rom
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Command/result handshake front-end that builds eight logic and
//            arithmetic commands out of micro-op sequences on an external
//            registered four-function ALU (result one cycle after inputs).
//            Optional macro ALU_SEQUENCER_XOR_EN enables the XOR command;
//            without it cmd_op 7 completes at once with res_err set.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err,
  output logic [7:0] alu_x,
  output logic [7:0] alu_y,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_z
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [2:0] op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [1:0] step;
  logic [7:0] t0;
  logic [7:0] t1;

  logic [1:0] rom_alu_op;
  logic [2:0] rom_x_src;
  logic [2:0] rom_y_src;
  logic       rom_save_t0;
  logic       rom_save_t1;
  logic       rom_last;
  logic [7:0] x_val;
  logic [7:0] y_val;

  wire cmd_fire = cmd_valid & cmd_ready;

  alu_sequencer_rom u_rom (
    .op      (op_q),
    .step    (step),
    .alu_op  (rom_alu_op),
    .x_src   (rom_x_src),
    .y_src   (rom_y_src),
    .save_t0 (rom_save_t0),
    .save_t1 (rom_save_t1),
    .last    (rom_last)
  );

  // Operand value for a given source; Z is the live ALU result
  function automatic logic [7:0] pick(input logic [2:0] src, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] z,
                                      input logic [7:0] x0, input logic [7:0] x1);
    case (src)
      SRC_A:   pick = a;
      SRC_B:   pick = b;
      SRC_Z:   pick = z;
      SRC_T0:  pick = x0;
      SRC_T1:  pick = x1;
      SRC_ONE: pick = 8'h01;
      default: pick = 8'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a rejected command skips straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (cmd_fire) state_next = cmd_supported(cmd_op) ? ST_STEP : ST_DONE;
      ST_STEP:    if (rom_last) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_DONE;
      ST_DONE:    if (res_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs: handshakes from state, ALU drive only while stepping
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    res_valid = (state == ST_DONE);
    alu_op    = ALU_ZERO;
    alu_x     = 8'h00;
    alu_y     = 8'h00;
    x_val     = pick(rom_x_src, a_q, b_q, alu_z, t0, t1);
    y_val     = pick(rom_y_src, a_q, b_q, alu_z, t0, t1);
    if (state == ST_STEP) begin
      alu_op = rom_alu_op;
      alu_x  = x_val;
      alu_y  = y_val;
    end
  end

  // Datapath: command latch, step counter, temporaries and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= 3'd0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      step     <= 2'd0;
      t0       <= 8'h00;
      t1       <= 8'h00;
      res_data <= 8'h00;
      res_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            op_q <= cmd_op;
            a_q  <= cmd_a;
            b_q  <= cmd_b;
            step <= 2'd0;
            if (!cmd_supported(cmd_op)) begin
              res_data <= 8'h00;
              res_err  <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (rom_save_t0) t0 <= alu_z;
          if (rom_save_t1) t1 <= alu_z;
          if (!rom_last)   step <= step + 2'd1;
        end
        ST_CAPTURE: begin
          res_data <= alu_z;
          res_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer with a model of
//            the external registered ALU. Expected values are hand-computed.
//            Honours ALU_SEQUENCER_XOR_EN for the XOR expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [7:0] res_data;
  logic       res_err;
  logic [7:0] alu_x;
  logic [7:0] alu_y;
  logic [1:0] alu_op;
  logic [7:0] alu_z = 8'h00;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    int         cyc;
  } vec_t;

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_op    (alu_op),
    .alu_z     (alu_z)
  );

  always #5 clk = ~clk;

  // External ALU: registered, result visible one cycle after its inputs
  always @(posedge clk) begin
    case (alu_op)
      2'b00:   alu_z <= alu_x + alu_y;
      2'b01:   alu_z <= ~(alu_x & alu_y);
      2'b10:   alu_z <= ~alu_x;
      default: alu_z <= 8'h00;
    endcase
  end

  // Offer one command for a single cycle (cycle 0), then count cycles until
  // res_valid is seen; returns with the bench inside the first DONE cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, output int cyc);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 8'h00) begin failures++; $display("FAIL reset_res_data got=%h exp=00", res_data); end
    checks++; if (res_err !== 1'b0) begin failures++; $display("FAIL reset_res_err got=%b exp=0", res_err); end
    checks++; if ({alu_op, alu_x, alu_y} !== {2'b11, 16'h0000}) begin
      failures++; $display("FAIL reset_alu got=%b/%h/%h exp=11/00/00", alu_op, alu_x, alu_y);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_step();
    vec_t v[5];
    int   cyc;
    v[0] = '{3'd0, 8'hF0, 8'h20, 8'h10, 3};
    v[1] = '{3'd1, 8'hF0, 8'h3C, 8'hCF, 3};
    v[2] = '{3'd2, 8'h5A, 8'h00, 8'hA5, 3};
    v[3] = '{3'd3, 8'h77, 8'h88, 8'h00, 3};
    v[4] = '{3'd0, 8'hFF, 8'h01, 8'h00, 3};
    for (int i = 0; i < 5; i++) begin
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL single_ready[%0d] got=%b exp=1", i, cmd_ready); end
      run_cmd(v[i].op, v[i].a, v[i].b, cyc);
      checks++; if (cyc !== v[i].cyc) begin failures++; $display("FAIL single_latency[%0d] got=%0d exp=%0d", i, cyc, v[i].cyc); end
      checks++; if (res_data !== v[i].exp || res_err !== 1'b0) begin
        failures++; $display("FAIL single_data[%0d] got=%h err=%b exp=%h err=0", i, res_data, res_err, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_step();
    vec_t v[4];
    int   cyc;
    v[0] = '{3'd6, 8'h05, 8'h07, 8'hFE, 5};
    v[1] = '{3'd4, 8'hF0, 8'h3C, 8'h30, 4};
    v[2] = '{3'd5, 8'hA0, 8'h0C, 8'hAC, 5};
    v[3] = '{3'd6, 8'h00, 8'h01, 8'hFF, 5};
    for (int i = 0; i < 4; i++) begin
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL multi_ready[%0d] got=%b exp=1", i, cmd_ready); end
      run_cmd(v[i].op, v[i].a, v[i].b, cyc);
      checks++; if (cyc !== v[i].cyc) begin failures++; $display("FAIL multi_latency[%0d] got=%0d exp=%0d", i, cyc, v[i].cyc); end
      checks++; if (res_data !== v[i].exp || res_err !== 1'b0) begin
        failures++; $display("FAIL multi_data[%0d] got=%h err=%b exp=%h err=0", i, res_data, res_err, v[i].exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_xor();
    int cyc;
`ifdef ALU_SEQUENCER_XOR_EN
    logic [7:0] exp_data = 8'hA5;
    logic       exp_err  = 1'b0;
    int         exp_cyc  = 6;
`else
    logic [7:0] exp_data = 8'h00;
    logic       exp_err  = 1'b1;
    int         exp_cyc  = 1;
`endif
    run_cmd(3'd7, 8'h5A, 8'hFF, cyc);
    checks++; if (cyc !== exp_cyc) begin failures++; $display("FAIL xor_latency got=%0d exp=%0d", cyc, exp_cyc); end
    checks++; if (res_data !== exp_data) begin failures++; $display("FAIL xor_data got=%h exp=%h", res_data, exp_data); end
    checks++; if (res_err !== exp_err) begin failures++; $display("FAIL xor_err got=%b exp=%b", res_err, exp_err); end
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL xor_back_idle got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_backpressure();
    int cyc;
    res_ready = 1'b0;
    run_cmd(3'd0, 8'h01, 8'h01, cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", cyc); end
    cmd_op = 3'd0; cmd_a = 8'h10; cmd_b = 8'h20; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({res_valid, cmd_ready, res_data} !== {1'b1, 1'b0, 8'h02}) begin
        failures++; $display("FAIL bp_hold[%0d] got valid=%b ready=%b data=%h exp valid=1 ready=0 data=02",
                             i, res_valid, cmd_ready, res_data);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if ({res_valid, cmd_ready, res_data} !== {1'b0, 1'b1, 8'h02}) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b data=%h exp valid=0 ready=1 data=02",
                           res_valid, cmd_ready, res_data);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    cmd_op = 3'd6; cmd_a = 8'h05; cmd_b = 8'h07; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if ({alu_op, alu_x} !== {2'b10, 8'h07}) begin
      failures++; $display("FAIL sub_step0 got op=%b x=%h exp op=10 x=07", alu_op, alu_x);
    end
    @(posedge clk); #1;
    checks++; if ({alu_op, alu_x, alu_y} !== {2'b00, 8'h05, 8'hF8}) begin
      failures++; $display("FAIL sub_step1 got op=%b x=%h y=%h exp op=00 x=05 y=F8", alu_op, alu_x, alu_y);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({cmd_ready, res_valid, res_data, res_err} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      failures++; $display("FAIL midrst_res got ready=%b valid=%b data=%h err=%b exp 1/0/00/0",
                           cmd_ready, res_valid, res_data, res_err);
    end
    checks++; if ({alu_op, alu_x, alu_y} !== {2'b11, 16'h0000}) begin
      failures++; $display("FAIL midrst_alu got=%b/%h/%h exp=11/00/00", alu_op, alu_x, alu_y);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(3'd0, 8'h03, 8'h04, cyc);
    checks++; if (cyc !== 3) begin failures++; $display("FAIL post_rst_latency got=%0d exp=3", cyc); end
    checks++; if (res_data !== 8'h07) begin failures++; $display("FAIL post_rst_data got=%h exp=07", res_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_multi_step();
    test_xor();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_sequencer
`default_nettype wire
